// File: rtl/fs_serial_if.sv
// Handshake and operand/result bundle for the bit-serial full subtractor.
// The master side issues operands and start; the slave side returns status and result.
interface fs_serial_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bi;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             bo;

    modport master (
        output start, a, b, bi,
        input  busy, done, d, bo
    );

    modport slave (
        input  start, a, b, bi,
        output busy, done, d, bo
    );
endinterface

// File: rtl/fs_serial.sv
// Bit-serial full subtractor: d = a - b - bi, one bit per clock, LSB first.
// A start accepted in IDLE or DONE launches WIDTH RUN cycles followed by a one-cycle done pulse.
module fs_serial #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    fs_serial_if.slave  bus
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             last_bit;
    logic             busy_c;
    logic             done_c;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] d_q;
    logic             bo_q;
    logic             br;
    logic [CW-1:0]    cnt;

    logic             br_nxt;
    logic             dbit;
    logic [WIDTH-1:0] r_nxt;

    // NOTE: the state register uses non-blocking assignments and an async
    // reset; everything combinational lives in always_comb with blocking ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        last_bit  = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_c   = 1'b1;
                last_bit = (cnt == LAST);
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_c = 1'b1;
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Full-subtractor truth table on {x, y, borrow} -> {borrow, diff}.
    always_comb begin
        {br_nxt, dbit} = 2'b00;
        unique case ({a_sh[0], b_sh[0], br})
            3'b000: {br_nxt, dbit} = 2'b00;
            3'b001: {br_nxt, dbit} = 2'b11;
            3'b010: {br_nxt, dbit} = 2'b11;
            3'b011: {br_nxt, dbit} = 2'b10;
            3'b100: {br_nxt, dbit} = 2'b01;
            3'b101: {br_nxt, dbit} = 2'b00;
            3'b110: {br_nxt, dbit} = 2'b00;
            3'b111: {br_nxt, dbit} = 2'b11;
            default: {br_nxt, dbit} = 2'b00;
        endcase
    end

    assign r_nxt = {dbit, r_sh[WIDTH-1:1]};

    // NOTE: the datapath is a handful of flops, not a memory array, so all of
    // it is cleared on reset to keep post-reset state fully deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh <= '0;
            b_sh <= '0;
            r_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
            d_q  <= '0;
            bo_q <= 1'b0;
        end else if (accept) begin
            a_sh <= bus.a;
            b_sh <= bus.b;
            br   <= bus.bi;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            br   <= br_nxt;
            r_sh <= r_nxt;
            cnt  <= cnt + 1'b1;
            // Result registers only move on the edge that enters DONE.
            if (last_bit) begin
                d_q  <= r_nxt;
                bo_q <= br_nxt;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.d    = d_q;
    assign bus.bo   = bo_q;

endmodule

// File: tb/tb_fs_serial.sv
// Scoreboard bench for fs_serial: the driver queues expected results, a monitor
// pops and compares on every done pulse and watches d/bo stay stable in between.
module tb_fs_serial;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             bo;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fs_serial_if #(.WIDTH(WIDTH)) bus ();

    fs_serial #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic bi);
        logic [WIDTH:0] r;
        exp_t e;
        r = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
        e.d  = r[WIDTH-1:0];
        e.bo = r[WIDTH];
        return e;
    endfunction

    // Monitor: compares on done, checks result hold otherwise.
    initial begin
        exp_t e;
        exp_t prev;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = {bus.d, bus.bo};
            end else if (bus.done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got d=%0d bo=%0d expected no done at %0t",
                             bus.d, bus.bo, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("result_d", 32'(bus.d), 32'(e.d));
                    check("result_bo", 32'(bus.bo), 32'(e.bo));
                end
                prev = {bus.d, bus.bo};
            end else begin
                check("hold_d_bo", 32'({bus.d, bus.bo}), 32'(prev));
            end
        end
    end

    task automatic wait_done(output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cycles++;
            if (bus.done) found = 1'b1;
        end
        if (!found) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles at %0t", $time);
        end
    endtask

    task automatic count_dones(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) cnt++;
        end
    endtask

    // Called at a negedge while the DUT is in IDLE or DONE.
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bi,
                          input exp_t e);
        int cyc;
        bus.a     = a;
        bus.b     = b;
        bus.bi    = bi;
        bus.start = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = WIDTH'($urandom);
        bus.b     = WIDTH'($urandom);
        bus.bi    = 1'($urandom);
        wait_done(cyc);
        check("latency", 32'(cyc + 1), 32'(WIDTH + 1));
    endtask

    initial begin
        int cyc;
        int busy_cnt;
        int n;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rbi;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bi    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_d", 32'(bus.d), 0);
        check("rst_bo", 32'(bus.bo), 0);
        #2 rst = 1'b0;
        @(negedge clk);

        // 1: 5 - 3 with latency and busy-length measurement
        bus.a = 8'd5; bus.b = 8'd3; bus.bi = 1'b0; bus.start = 1'b1;
        exp_q.push_back('{d: 8'd2, bo: 1'b0});
        cyc = 0;
        busy_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            cyc++;
            if (bus.busy) busy_cnt++;
            if (bus.done) break;
        end
        check("t1_latency", 32'(cyc), 9);
        check("t1_busy_cycles", 32'(busy_cnt), 8);
        check("t1_done_seen", 32'(bus.done), 1);

        // 2: borrow cases
        run_op(8'd3, 8'd5, 1'b0, '{d: 8'hFE, bo: 1'b1});
        run_op(8'd0, 8'd0, 1'b1, '{d: 8'hFF, bo: 1'b1});
        run_op(8'd255, 8'd255, 1'b1, '{d: 8'hFF, bo: 1'b1});
        run_op(8'd255, 8'd0, 1'b0, '{d: 8'hFF, bo: 1'b0});
        run_op(8'd128, 8'd127, 1'b1, '{d: 8'h00, bo: 1'b0});
        repeat (2) @(negedge clk);

        // 3: back-to-back with start held high
        bus.a = 8'd200; bus.b = 8'd55; bus.bi = 1'b0; bus.start = 1'b1;
        exp_q.push_back('{d: 8'd145, bo: 1'b0});
        @(negedge clk);
        bus.a = 8'd10; bus.b = 8'd20; bus.bi = 1'b0;
        exp_q.push_back('{d: 8'd246, bo: 1'b1});
        wait_done(cyc);
        check("t3_first_latency", 32'(cyc + 1), 9);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a = 8'd0; bus.b = 8'd0;
        wait_done(cyc);
        check("t3_spacing", 32'(cyc + 1), 9);
        count_dones(12, n);
        check("t3_no_extra_done", 32'(n), 0);

        // 4: start pulse mid-RUN is ignored
        bus.a = 8'd100; bus.b = 8'd30; bus.bi = 1'b1; bus.start = 1'b1;
        exp_q.push_back('{d: 8'd69, bo: 1'b0});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        bus.a = 8'd99; bus.b = 8'd1; bus.bi = 1'b0; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        check("t4_latency", 32'(cyc + 5), 9);
        count_dones(15, n);
        check("t4_single_done", 32'(n), 0);

        // 5: reset four cycles into RUN
        bus.a = 8'd77; bus.b = 8'd7; bus.bi = 1'b0; bus.start = 1'b1;
        exp_q.push_back('{d: 8'd70, bo: 1'b0});
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_busy_before", 32'(bus.busy), 1);
        #2 rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_busy", 32'(bus.busy), 0);
        check("t5_done", 32'(bus.done), 0);
        check("t5_d", 32'(bus.d), 0);
        check("t5_bo", 32'(bus.bo), 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        count_dones(12, n);
        check("t5_no_done", 32'(n), 0);
        run_op(8'd40, 8'd15, 1'b1, '{d: 8'd24, bo: 1'b0});

        // 6: random operands against the reference model
        for (int i = 0; i < 2000; i++) begin
            ra  = WIDTH'($urandom);
            rb  = WIDTH'($urandom);
            rbi = 1'($urandom);
            run_op(ra, rb, rbi, model(ra, rb, rbi));
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
